// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: RV32I fetch/decode stage, one outstanding imem request, valid/ready bundle register.
// Define ILLEGAL_CHECK_EN to compute ILLEGAL; otherwise it is tied low.
module instr_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        dec_ready_i,
  output logic        dec_valid_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct1_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [11:0] imm12_o,
  output logic [19:0] u_imm20_o,
  output logic        illegal_o
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        valid_q, valid_d, load;
  logic [31:0] w;
  logic [11:0] imm12;
  logic [19:0] u_imm20;
  logic        unused_pc_lsb;
  assign w = imem_rdata_i;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign imem_req_o = state_q == FETCH;
  assign imem_addr_o = fpc_q;
  assign dec_valid_o = valid_q;
  assign imm12 = w[6:0] == 7'b0100011 ? {w[31:25], w[11:7]} :
                 w[6:0] == 7'b1100011 ? {w[31], w[7], w[30:25], w[11:8]} : w[31:20];
  assign u_imm20 = w[6:0] == 7'b1101111 ? {w[31], w[19:12], w[20], w[30:21]} : w[31:12];
  always_comb begin
    state_d = state_q;
    fpc_d = fpc_q;
    valid_d = valid_q;
    load = 1'b0;
    if (redirect_i) begin
      fpc_d = {redirect_pc_i[31:2], 2'b00};
      valid_d = 1'b0;
      // an in-flight response must still be swallowed before the next request
      state_d = ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid_i) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = WAIT;
        WAIT: if (imem_rvalid_i) begin
          load = 1'b1;
          valid_d = 1'b1;
          fpc_d = fpc_q + 32'd4;
          state_d = HOLD;
        end
        HOLD: if (dec_ready_i) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
        DRAIN: state_d = imem_rvalid_i ? FETCH : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_o <= RESET_PC;
      opcode_o <= '0;
      funct3_o <= '0;
      funct1_o <= 1'b0;
      rs1_o <= '0;
      rs2_o <= '0;
      rd_o <= '0;
      imm12_o <= '0;
      u_imm20_o <= '0;
    end else if (load) begin
      pc_o <= fpc_q;
      opcode_o <= w[6:0];
      funct3_o <= w[14:12];
      funct1_o <= w[30];
      rs1_o <= w[19:15];
      rs2_o <= w[24:20];
      rd_o <= w[11:7];
      imm12_o <= imm12;
      u_imm20_o <= u_imm20;
    end
  end
`ifdef ILLEGAL_CHECK_EN
  logic ill, ill_q;
  assign ill = w[1:0] != 2'b11 || !(w[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
               7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011});
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ill_q <= 1'b0;
    else if (load) ill_q <= ill;
  end
  assign illegal_o = ill_q;
`else
  assign illegal_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed vector table, corner sequences, and randomized run against a
// transaction-level reference model of instr_fetch_decode (plus a RESET_PC wrap instance).
module tb_instr_fetch_decode;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, rvalid, redirect, ready, req, valid, funct1, ill;
  logic [31:0] rdata, redirect_pc, addr, pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm12;
  logic [19:0] u20;
  logic        rst1_n, rvalid1, ready1, req1, valid1, f1_1, ill1;
  logic [31:0] rdata1, addr1, pc1;
  logic [6:0]  op1;
  logic [2:0]  f3_1;
  logic [4:0]  rs1_1, rs2_1, rd_1;
  logic [11:0] i12_1;
  logic [19:0] u20_1;
  int n_cmp = 0, n_bad = 0;
  logic ill_en;

  instr_fetch_decode dut (
    .clk_i(clk), .rst_n_i(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .dec_ready_i(ready),
    .dec_valid_o(valid), .pc_o(pc), .opcode_o(opcode), .funct3_o(funct3), .funct1_o(funct1),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm12_o(imm12), .u_imm20_o(u20), .illegal_o(ill));

  instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .rst_n_i(rst1_n), .imem_req_o(req1), .imem_addr_o(addr1), .imem_rvalid_i(rvalid1),
    .imem_rdata_i(rdata1), .redirect_i(1'b0), .redirect_pc_i(32'h0), .dec_ready_i(ready1),
    .dec_valid_o(valid1), .pc_o(pc1), .opcode_o(op1), .funct3_o(f3_1), .funct1_o(f1_1),
    .rs1_o(rs1_1), .rs2_o(rs2_1), .rd_o(rd_1), .imm12_o(i12_1), .u_imm20_o(u20_1), .illegal_o(ill1));

  typedef struct {
    logic [31:0] w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] i12;
    logic [19:0] u20;
    logic        il;
    int          lat;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Immediates reconstructed from the architectural branch/jump offsets (offset >> 1).
  function automatic logic [11:0] ref_imm12(input logic [31:0] w);
    logic [31:0] off;
    case (w & 32'h7F)
      32'h23: return 12'(((w >> 25) << 5) | ((w >> 7) & 32'h1F));
      32'h63: begin
        off = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        return 12'(off >> 1);
      end
      default: return 12'(w >> 20);
    endcase
  endfunction

  function automatic logic [19:0] ref_u20(input logic [31:0] w);
    logic [31:0] off;
    if ((w & 32'h7F) == 32'h6F) begin
      off = (((w >> 31) & 1) << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      return 20'(off >> 1);
    end
    return 20'(w >> 12);
  endfunction

  function automatic logic ref_ill(input logic [31:0] w);
    logic [6:0] op;
    op = 7'(w & 32'h7F);
    return ill_en && ((w & 3) != 3 || !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73}));
  endfunction

  task automatic chk_dec(input string t, input logic [31:0] w, input logic [31:0] p);
    chk({t, "_op"}, 32'(opcode), w & 32'h7F);
    chk({t, "_f3"}, 32'(funct3), (w >> 12) & 7);
    chk({t, "_f1"}, 32'(funct1), (w >> 30) & 1);
    chk({t, "_rs1"}, 32'(rs1), (w >> 15) & 31);
    chk({t, "_rs2"}, 32'(rs2), (w >> 20) & 31);
    chk({t, "_rd"}, 32'(rd), (w >> 7) & 31);
    chk({t, "_imm12"}, 32'(imm12), 32'(ref_imm12(w)));
    chk({t, "_u20"}, 32'(u20), 32'(ref_u20(w)));
    chk({t, "_ill"}, 32'(ill), 32'(ref_ill(w)));
    chk({t, "_pc"}, pc, p);
  endtask

  task automatic wait_req(input string t, output int n);
    n = -1;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      @(negedge clk);
      if (req) n = i;
    end
    if (n < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no IMEM_REQ within 30 cycles", t);
    end
  endtask

  task automatic respond(input logic [31:0] w, input int lat);
    repeat (lat) @(negedge clk);
    rvalid = 1'b1;
    rdata = w;
    @(negedge clk);
    rvalid = 1'b0;
    rdata = 32'hDEAD_BEEF;
  endtask

  logic [6:0]  ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h2B};
  logic        pend, outst, stale, live, rv, rdr, rdy;
  logic [31:0] efpc, epc, ew, raddr, r, wd, tgt;
  int          cnt, lat, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef ILLEGAL_CHECK_EN
    ill_en = 1'b1;
`else
    ill_en = 1'b0;
`endif
    tbl[0] = '{32'h00A00093, 7'h13, 3'd0, 5'd1,  5'd0, 12'h00A, 20'h00A00, 1'b0, 1};
    tbl[1] = '{32'hFE209EE3, 7'h63, 3'd1, 5'h1D, 5'd1, 12'hFFE, 20'hFE209, 1'b0, 2};
    tbl[2] = '{32'h0080006F, 7'h6F, 3'd0, 5'd0,  5'd0, 12'h008, 20'h00004, 1'b0, 1};
    tbl[3] = '{32'h123450B7, 7'h37, 3'd5, 5'd1,  5'd8, 12'h123, 20'h12345, 1'b0, 3};
    tbl[4] = '{32'h00000013, 7'h13, 3'd0, 5'd0,  5'd0, 12'h000, 20'h00000, 1'b0, 1};
    tbl[5] = '{32'h00000000, 7'h00, 3'd0, 5'd0,  5'd0, 12'h000, 20'h00000, 1'b1, 2};
    rst_n = 1'b0; rvalid = 1'b0; rdata = '0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    rst1_n = 1'b0; rvalid1 = 1'b0; rdata1 = '0; ready1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_pc", pc, 0);
    chk("rst_op", 32'(opcode), 0);
    chk("rst_imm12", 32'(imm12), 0);
    chk("rst_u20", 32'(u20), 0);
    chk("rst_ill", 32'(ill), 0);
    chk("rst1_addr", addr1, 32'hFFFF_FFFC);
    chk("rst1_pc", pc1, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    epc = 0;
    for (int i = 0; i < 6; i++) begin
      wait_req("tbl_req", n);
      if (i == 0) chk("first_req_cycle", 32'(n), 1);
      ready = 1'b0;
      chk("tbl_addr", addr, epc);
      respond(tbl[i].w, tbl[i].lat);
      chk("tbl_valid", 32'(valid), 1);
      chk("tbl_req_low", 32'(req), 0);
      chk("tbl_op", 32'(opcode), 32'(tbl[i].op));
      chk("tbl_f3", 32'(funct3), 32'(tbl[i].f3));
      chk("tbl_rd", 32'(rd), 32'(tbl[i].rd));
      chk("tbl_rs1", 32'(rs1), 32'(tbl[i].rs1));
      chk("tbl_imm12", 32'(imm12), 32'(tbl[i].i12));
      chk("tbl_u20", 32'(u20), 32'(tbl[i].u20));
      chk("tbl_ill", 32'(ill), 32'(tbl[i].il & ill_en));
      chk("tbl_pc", pc, epc);
      if (i == 1)
        repeat (5) begin
          @(negedge clk);
          chk("stall_req", 32'(req), 0);
          chk("stall_valid", 32'(valid), 1);
          chk_dec("stall", tbl[i].w, epc);
        end
      ready = 1'b1;
      epc += 4;
    end
    // Redirect while WAIT with 3-cycle latency: stale word must vanish.
    wait_req("rd_req", n);
    ready = 1'b0;
    chk("rd_addr0", addr, 32'd24);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    chk("rd_valid1", 32'(valid), 0);
    chk("rd_req1", 32'(req), 0);
    @(negedge clk);
    chk("rd_valid2", 32'(valid), 0);
    chk("rd_req2", 32'(req), 0);
    rvalid = 1'b1;
    rdata = 32'h00000093;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rd_valid3", 32'(valid), 0);
    chk("rd_req3", 32'(req), 1);
    chk("rd_addr", addr, 32'h0000_0100);
    respond(32'h00500113, 1);
    chk("rd_new_valid", 32'(valid), 1);
    chk_dec("rd_new", 32'h00500113, 32'h100);
    ready = 1'b1;
    // Randomized run against the transaction-level model.
    @(negedge clk);
    pend = 0; outst = 0; stale = 0; efpc = 32'h104; cnt = 0; lat = 1; raddr = 0; ew = 0; epc = 0;
    for (int c = 0; c < 700; c++) begin
      if (req) begin
        chk("rnd_addr", addr, efpc);
        chk("rnd_req_busy", 32'(outst | pend), 0);
        outst = 1; stale = 0; cnt = 0; lat = $urandom_range(1, 3); raddr = addr;
      end
      chk("rnd_valid", 32'(valid), 32'(pend));
      if (valid) chk_dec("rnd", ew, epc);
      if (c >= 500 && valid) break;
      live = outst && !req;
      if (live) cnt++;
      rv = live ? (cnt >= lat) : ($urandom_range(0, 3) == 0);
      rdr = !req && c > 10 && $urandom_range(0, 9) == 0;
      rdy = $urandom_range(0, 2) != 0;
      r = $urandom;
      wd = ($urandom_range(0, 7) == 0) ? r : {r[31:7], ops[$urandom_range(0, 11)]};
      tgt = $urandom;
      rvalid = rv; rdata = wd; redirect = rdr; redirect_pc = tgt; ready = rdy;
      if (valid && (rdy || rdr)) pend = 0;
      if (rv && live) begin
        outst = 0;
        if (!stale && !rdr) begin
          pend = 1; ew = wd; epc = raddr; efpc = raddr + 4;
        end
      end
      if (rdr) begin
        efpc = tgt & ~32'd3;
        if (outst) stale = 1;
      end
      @(negedge clk);
    end
    // Async reset mid-operation, then responses in IDLE/FETCH must be ignored.
    #2;
    rst_n = 1'b0; rvalid = 1'b0; redirect = 1'b0; ready = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 0);
    chk("async_req", 32'(req), 0);
    chk("async_pc", pc, 0);
    chk("async_addr", addr, 0);
    chk("async_op", 32'(opcode), 0);
    chk("async_ill", 32'(ill), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rvalid = 1'b1;
    rdata = 32'h00000013;
    @(negedge clk);
    chk("ign_req", 32'(req), 1);
    @(negedge clk);
    rvalid = 1'b0;
    chk("ign_valid", 32'(valid), 0);
    @(negedge clk);
    chk("ign_valid2", 32'(valid), 0);
    rvalid = 1'b1;
    rdata = 32'h00A00093;
    @(negedge clk);
    rvalid = 1'b0;
    chk("post_valid", 32'(valid), 1);
    chk_dec("post", 32'h00A00093, 0);
    // RESET_PC at the top of the address space wraps to 0.
    rst1_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      @(negedge clk);
      if (req1) n = i;
    end
    chk("wrap_req_found", 32'(n), 1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    rvalid1 = 1'b1;
    rdata1 = 32'h00000013;
    @(negedge clk);
    rvalid1 = 1'b0;
    chk("wrap_valid", 32'(valid1), 1);
    chk("wrap_pc", pc1, 32'hFFFF_FFFC);
    ready1 = 1'b1;
    @(negedge clk);
    chk("wrap_req1", 32'(req1), 1);
    chk("wrap_addr1", addr1, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode stage for the RV32I core: issues one instruction-memory request at a time, decodes the returned word into the field bundle the ALU stage consumes (OPCODE, FUNCT3, FUNCT1, RS1/RS2/RD, IMM12, U_IMM20, PC), and presents it through a valid/ready output register. It sits between instruction memory and the ALU/control stage. It maintains the architectural fetch PC and accepts redirects from the branch/jump resolution logic.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset

- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IMEM_REQ  out  1  one-cycle request pulse
- IMEM_ADDR  out  32  fetch address, valid while IMEM_REQ=1
- IMEM_RVALID  in  1  response valid, ≥1 cycle after request
- IMEM_RDATA  in  32  instruction word, valid with IMEM_RVALID
- REDIRECT  in  1  load new PC, flush stage
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored (forced 00)
- DEC_READY  in  1  downstream accepts bundle
- DEC_VALID  out  1  bundle valid
- PC  out  32  address of decoded instruction
- OPCODE  out  7  instr[6:0]
- FUNCT3  out  3  instr[14:12]
- FUNCT1  out  1  instr[30]
- RS1 / RS2 / RD  out  5 each  instr[19:15] / instr[24:20] / instr[11:7]
- IMM12  out  12  type-selected 12-bit immediate
- U_IMM20  out  20  type-selected 20-bit immediate
- ILLEGAL  out  1  decoded word not legal RV32I (see Configuration)

## Operation
- Internal fetch PC register fpc; output bundle is a register loaded on accepted response.
- States: IDLE (reset), FETCH, WAIT, HOLD, DRAIN.
  - IDLE → FETCH unconditionally.
  - FETCH: IMEM_REQ=1, IMEM_ADDR=fpc; → WAIT.
  - WAIT: on IMEM_RVALID load bundle (PC=fpc), DEC_VALID←1, fpc←fpc+4; → HOLD.
  - HOLD: DEC_VALID=1; on DEC_READY, DEC_VALID←0; → FETCH.
  - DRAIN: discard response; on IMEM_RVALID → FETCH.
- IMM12 select by OPCODE: S-type (0100011) {instr[31:25],instr[11:7]}; B-type (1100011) {instr[31],instr[7],instr[30:25],instr[11:8]}; all others instr[31:20].
- U_IMM20 select: J-type (1101111) {instr[31],instr[19:12],instr[20],instr[30:21]}; all others instr[31:12].
- fpc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- REDIRECT has priority over all other transitions:
  - fpc←{REDIRECT_PC[31:2],2'b00}, DEC_VALID←0.
  - From IDLE/FETCH/HOLD → FETCH.
  - From WAIT without same-cycle IMEM_RVALID → DRAIN, so the outstanding response is discarded.
  - From WAIT with same-cycle IMEM_RVALID: response discarded → FETCH.
  - From DRAIN: fpc updated, remain in DRAIN unless IMEM_RVALID, which → FETCH.
- REDIRECT with DEC_VALID && DEC_READY in the same cycle: the held bundle counts as consumed, and the redirect still applies.
- IMEM_RVALID outside WAIT/DRAIN is ignored.
- Bundle fields stay stable while DEC_VALID=1 and DEC_READY=0.

## Timing
- Reset values:
  - IMEM_REQ=0, IMEM_ADDR=RESET_PC, DEC_VALID=0, ILLEGAL=0.
  - PC=RESET_PC, all other decode fields 0.
  - fpc=RESET_PC, state IDLE.
- Async assertion of RST_N clears everything immediately, including mid-fetch. Any later response is then ignored, because IDLE/FETCH ignore RVALID.
- First IMEM_REQ is high in the cycle after the first rising edge following RST_N release.
- Response in cycle N+k (k≥1) after a FETCH in cycle N → DEC_VALID high from cycle N+k+1.
- Best-case throughput: one instruction per 3 cycles (FETCH, WAIT, HOLD, with 1-cycle memory and DEC_READY=1).
- IMEM_ADDR/IMEM_REQ are state-decoded, with no combinational path from inputs.
- DEC_VALID and all bundle fields are registered.

## Configuration
- ILLEGAL_CHECK_EN defined: ILLEGAL is registered with the bundle and is 1 when either of these holds:
  - instr[1:0]≠2'b11;
  - OPCODE is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
- Not defined: ILLEGAL is tied to 0, and the port remains present.

## Test plan
- Reset release, memory returns 32'h00A00093 one cycle after the request → IMEM_ADDR=0 on the first request; DEC_VALID with OPCODE=0010011, RD=1, RS1=0, IMM12=12'h00A, PC=0; next request at address 4.
- DEC_READY held 0 for 5 cycles with bundle 32'hFE209EE3 (BNE) → fields stable and no IMEM_REQ during the stall; IMM12=12'hFFE, FUNCT3=001.
- JAL 32'h0080006F → U_IMM20=20'h00004; LUI 32'h123450B7 → U_IMM20=20'h12345, RD=1.
- REDIRECT to 32'h0000_0103 while in WAIT with 3-cycle memory latency → stale response discarded; next IMEM_ADDR=32'h0000_0100; no DEC_VALID for the stale word.
- RESET_PC=32'hFFFF_FFFC, accept one instruction → second IMEM_ADDR=0.
- With ILLEGAL_CHECK_EN, word 32'h0000_0000 → ILLEGAL=1; word 32'h00000013 → ILLEGAL=0; without the macro, ILLEGAL stays 0 for both words.
